// File: rtl/hd63701_pkg.sv
// Shared encodings for the HD63701 core: microcode word fields, opcodes, register and
// addressing codes, phase constants and interrupt vectors.
package hd63701_pkg;

  localparam int MCW_W  = 25;
  localparam int OP_W   = 6;
  localparam int REG_W  = 4;
  localparam int PH_W   = 3;
  localparam int AM_W   = 3;

  localparam int OP_LSB = 19;
  localparam int R1_LSB = 15;
  localparam int R2_LSB = 11;
  localparam int R3_LSB = 7;
  localparam int PH_LSB = 4;
  localparam int AM_LSB = 1;
  localparam int PC_LSB = 0;

  typedef enum logic [OP_W-1:0] {
    mcNOP = 6'd0,  mcLDV = 6'd1,  mcVHI = 6'd2,  mcVLO = 6'd3,
    mcINT = 6'd4,  mcSCB = 6'd5,  mcCCB = 6'd6,  mcCLR = 6'd7,
    mcINC = 6'd8,  mcDEC = 6'd9,  mcMOV = 6'd10, mcPSH = 6'd11
  } mc_op_e;

  // Byte-lane codes for PC and IX exist so pushes can name each half directly.
  typedef enum logic [REG_W-1:0] {
    mcrn  = 4'd0, mcrA  = 4'd1, mcrB  = 4'd2, mcrC  = 4'd3,
    mcrX  = 4'd4, mcrP  = 4'd5, mcrPL = 4'd6, mcrPH = 4'd7,
    mcrXL = 4'd8, mcrXH = 4'd9
  } mc_reg_e;

  typedef enum logic [PH_W-1:0] {
    mcpN = 3'd0, mcp0 = 3'd1, mcpI = 3'd2, mcpV = 3'd3,
    mcpH = 3'd4, mcpS = 3'd5, mcpK = 3'd7
  } mc_ph_e;

  typedef enum logic [AM_W-1:0] {
    amPC = 3'd0, amSP = 3'd1, amE0 = 3'd2, amE1 = 3'd3
  } mc_am_e;

  localparam logic pcN = 1'b0;
  localparam logic pcI = 1'b1;

  localparam logic [7:0] bfC = 8'h01;
  localparam logic [7:0] bfI = 8'h10;

  localparam logic [7:0] vaNMI = 8'hFC;
  localparam logic [7:0] vaSWI = 8'hFA;
  localparam logic [7:0] vaIRQ = 8'hF8;
  localparam logic [7:0] vaWAI = 8'h00;

  localparam logic [5:0] phRST   = 6'h00;
  localparam logic [5:0] phVECT  = 6'h04;
  localparam logic [5:0] phEXEC  = 6'h08;
  localparam logic [5:0] phINTR  = 6'h20;
  localparam logic [5:0] phINTR8 = 6'h28;
  localparam logic [5:0] phINTR9 = 6'h29;
  localparam logic [5:0] phSLEP  = 6'h30;
  localparam logic [5:0] phHALT  = 6'h3F;

  function automatic logic [MCW_W-1:0] mc_word(mc_op_e op, mc_reg_e r1, mc_reg_e r2,
                                               mc_reg_e r3, mc_ph_e ph, mc_am_e am,
                                               logic pc);
    return {op, r1, r2, r3, ph, am, pc};
  endfunction

  // An 8-bit constant (vector or flag mask) overlays the r1:r2 fields.
  function automatic logic [MCW_W-1:0] mc_kword(mc_op_e op, logic [7:0] k, mc_reg_e r3,
                                                mc_ph_e ph, mc_am_e am, logic pc);
    return {op, k, r3, ph, am, pc};
  endfunction

endpackage

// File: rtl/hd63701_mcrom.sv
// Microcode ROM: registered lookup of (PHASE, OPCODE) into a 25-bit control word.
// Build option MCROM_UNDEF_NOP_EN: undefined EXEC opcodes yield NOP instead of HALT.
module hd63701_mcrom
  import hd63701_pkg::*;
#(
  parameter int MCW = 25
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [5:0]     PHASE,
  input  logic [7:0]     OPCODE,
  output logic [MCW-1:0] MCODE
);

  logic [MCW-1:0] r_mcode;
  logic [MCW-1:0] w_mcode;
  logic [MCW-1:0] w_halt;
  logic [MCW-1:0] w_nop;
  logic [MCW-1:0] w_exec_undef;

  assign w_halt = mc_word(mcNOP, mcrn, mcrn, mcrn, mcpH, amPC, pcN);
  assign w_nop  = mc_word(mcNOP, mcrn, mcrn, mcrn, mcp0, amPC, pcI);

`ifdef MCROM_UNDEF_NOP_EN
  assign w_exec_undef = w_nop;
`else
  assign w_exec_undef = w_halt;
`endif

  always_comb begin
    w_mcode = w_halt;
    casez (PHASE)
      phRST:      w_mcode = mc_kword(mcLDV, 8'hFE, mcrn, mcpV, amE0, pcN);
      phVECT:     w_mcode = mc_word(mcVHI, mcrn, mcrn, mcrn, mcpN, amE0, pcN);
      phVECT + 6'd1:
                  w_mcode = mc_word(mcVLO, mcrn, mcrn, mcrn, mcp0, amE1, pcN);
      phEXEC: begin
        case (OPCODE)
          8'h01: w_mcode = w_nop;
          8'h4F: w_mcode = mc_word(mcCLR, mcrA, mcrn, mcrn, mcp0, amPC, pcI);
          8'h5F: w_mcode = mc_word(mcCLR, mcrB, mcrn, mcrn, mcp0, amPC, pcI);
          8'h4C: w_mcode = mc_word(mcINC, mcrA, mcrn, mcrn, mcp0, amPC, pcI);
          8'h5C: w_mcode = mc_word(mcINC, mcrB, mcrn, mcrn, mcp0, amPC, pcI);
          8'h4A: w_mcode = mc_word(mcDEC, mcrA, mcrn, mcrn, mcp0, amPC, pcI);
          8'h5A: w_mcode = mc_word(mcDEC, mcrB, mcrn, mcrn, mcp0, amPC, pcI);
          // MOV: r1 is the destination, r2 the source.
          8'h16: w_mcode = mc_word(mcMOV, mcrB, mcrA, mcrn, mcp0, amPC, pcI);
          8'h17: w_mcode = mc_word(mcMOV, mcrA, mcrB, mcrn, mcp0, amPC, pcI);
          8'h0C: w_mcode = mc_kword(mcCCB, bfC, mcrn, mcp0, amPC, pcI);
          8'h0D: w_mcode = mc_kword(mcSCB, bfC, mcrn, mcp0, amPC, pcI);
          8'h0E: w_mcode = mc_kword(mcCCB, bfI, mcrn, mcp0, amPC, pcI);
          8'h0F: w_mcode = mc_kword(mcSCB, bfI, mcrn, mcp0, amPC, pcI);
          8'h3F: w_mcode = mc_kword(mcINT, vaSWI, mcrn, mcpI, amPC, pcI);
          8'h3E: w_mcode = mc_kword(mcINT, vaWAI, mcrn, mcpI, amPC, pcI);
          8'h1A: w_mcode = mc_word(mcNOP, mcrn, mcrn, mcrn, mcpS, amPC, pcI);
          default: w_mcode = w_exec_undef;
        endcase
      end
      6'b10_0???: begin
        case (PHASE[2:0])
          3'd0: w_mcode = mc_word(mcPSH, mcrPL, mcrn, mcrn, mcpN, amSP, pcN);
          3'd1: w_mcode = mc_word(mcPSH, mcrPH, mcrn, mcrn, mcpN, amSP, pcN);
          3'd2: w_mcode = mc_word(mcPSH, mcrXL, mcrn, mcrn, mcpN, amSP, pcN);
          3'd3: w_mcode = mc_word(mcPSH, mcrXH, mcrn, mcrn, mcpN, amSP, pcN);
          3'd4: w_mcode = mc_word(mcPSH, mcrA,  mcrn, mcrn, mcpN, amSP, pcN);
          3'd5: w_mcode = mc_word(mcPSH, mcrB,  mcrn, mcrn, mcpN, amSP, pcN);
          3'd6: w_mcode = mc_word(mcPSH, mcrC,  mcrn, mcrn, mcpN, amSP, pcN);
          default: w_mcode = mc_word(mcNOP, mcrn, mcrn, mcrn, mcpN, amSP, pcN);
        endcase
      end
      default: w_mcode = w_halt;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_mcode <= '0;
    end else begin
      r_mcode <= w_mcode;
    end
  end

  assign MCODE = r_mcode;

endmodule

// File: tb/tb_hd63701_mcrom.sv
// Directed-vector bench for hd63701_mcrom; expected words are packed from hand-chosen field values.
module tb_hd63701_mcrom;

  logic        CLK;
  logic        RST;
  logic [5:0]  PHASE;
  logic [7:0]  OPCODE;
  logic [24:0] MCODE;

  int n_cmp;
  int n_bad;

  hd63701_mcrom dut (
    .CLK    (CLK),
    .RST    (RST),
    .PHASE  (PHASE),
    .OPCODE (OPCODE),
    .MCODE  (MCODE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Field codes: op NOP0 LDV1 VHI2 VLO3 INT4 SCB5 CCB6 CLR7 INC8 DEC9 MOV10 PSH11;
  // reg n0 A1 B2 C3 PL6 PH7 XL8 XH9; ph N0 01 I2 V3 H4 S5; am PC0 SP1 E0=2 E1=3.
  function automatic logic [24:0] w(int op, int r1, int r2, int r3, int ph, int am, int pc);
    logic [5:0] f_op;
    logic [3:0] f_r1;
    logic [3:0] f_r2;
    logic [3:0] f_r3;
    logic [2:0] f_ph;
    logic [2:0] f_am;
    logic       f_pc;
    f_op = op[5:0];
    f_r1 = r1[3:0];
    f_r2 = r2[3:0];
    f_r3 = r3[3:0];
    f_ph = ph[2:0];
    f_am = am[2:0];
    f_pc = pc[0];
    return {f_op, f_r1, f_r2, f_r3, f_ph, f_am, f_pc};
  endfunction

  task automatic check(input string tag, input logic [24:0] got, input logic [24:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %07h expected %07h", tag, got, exp);
    end else begin
      $display("ok   %s: %07h", tag, got);
    end
  endtask

  task automatic step(input string tag, input logic [5:0] ph, input logic [7:0] op,
                      input logic [24:0] exp);
    @(negedge CLK);
    PHASE  = ph;
    OPCODE = op;
    @(posedge CLK);
    #1;
    check(tag, MCODE, exp);
  endtask

  logic [24:0] halt_w;
  logic [24:0] nop_w;
  logic [24:0] undef_exp;
  logic [24:0] psh_exp [8];
  int          psh_reg [8];

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    halt_w = w(0, 0, 0, 0, 4, 0, 0);
    nop_w  = w(0, 0, 0, 0, 1, 0, 1);
`ifdef MCROM_UNDEF_NOP_EN
    undef_exp = nop_w;
`else
    undef_exp = halt_w;
`endif
    psh_reg = '{6, 7, 8, 9, 1, 2, 3, 0};
    for (int i = 0; i < 7; i++) psh_exp[i] = w(11, psh_reg[i], 0, 0, 0, 1, 0);
    psh_exp[7] = w(0, 0, 0, 0, 0, 1, 0);

    RST    = 1'b1;
    PHASE  = 6'h08;
    OPCODE = 8'h01;
    @(posedge CLK); #1;
    check("rst_cycle1", MCODE, 25'h0);
    @(posedge CLK); #1;
    check("rst_cycle2", MCODE, 25'h0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;
    check("exec_nop_after_rst", MCODE, nop_w);

    step("ph_rst",     6'h00, 8'h00, w(1, 4'hF, 4'hE, 0, 3, 2, 0));
    step("ph_vect",    6'h04, 8'h55, w(2, 0, 0, 0, 0, 2, 0));
    step("ph_vect1",   6'h05, 8'h55, w(3, 0, 0, 0, 1, 3, 0));
    step("swi",        6'h08, 8'h3F, w(4, 4'hF, 4'hA, 0, 2, 0, 1));
    for (int i = 0; i < 8; i++) begin
      step($sformatf("intr%0d", i), 6'h20 + 6'(i), 8'h3F, psh_exp[i]);
    end
    step("wai",        6'h08, 8'h3E, w(4, 0, 0, 0, 2, 0, 1));
    step("slp",        6'h08, 8'h1A, w(0, 0, 0, 0, 5, 0, 1));
    step("sei",        6'h08, 8'h0F, w(5, 1, 0, 0, 1, 0, 1));
    step("cli",        6'h08, 8'h0E, w(6, 1, 0, 0, 1, 0, 1));
    step("sec",        6'h08, 8'h0D, w(5, 0, 1, 0, 1, 0, 1));
    step("clc",        6'h08, 8'h0C, w(6, 0, 1, 0, 1, 0, 1));
    step("clra",       6'h08, 8'h4F, w(7, 1, 0, 0, 1, 0, 1));
    step("clrb",       6'h08, 8'h5F, w(7, 2, 0, 0, 1, 0, 1));
    step("inca",       6'h08, 8'h4C, w(8, 1, 0, 0, 1, 0, 1));
    step("incb",       6'h08, 8'h5C, w(8, 2, 0, 0, 1, 0, 1));
    step("deca",       6'h08, 8'h4A, w(9, 1, 0, 0, 1, 0, 1));
    step("decb",       6'h08, 8'h5A, w(9, 2, 0, 0, 1, 0, 1));
    step("tab",        6'h08, 8'h16, w(10, 2, 1, 0, 1, 0, 1));
    step("tba",        6'h08, 8'h17, w(10, 1, 2, 0, 1, 0, 1));
    step("exec_undef", 6'h08, 8'h02, undef_exp);
    step("exec_undef_ff", 6'h08, 8'hFF, undef_exp);
    step("ph15_halt",  6'h15, 8'h01, halt_w);
    step("intr8_halt", 6'h28, 8'h01, halt_w);
    step("intr9_halt", 6'h29, 8'h01, halt_w);
    step("slep_halt",  6'h30, 8'h01, halt_w);
    step("halt_halt",  6'h3F, 8'h01, halt_w);

    // Output must hold between edges even when the inputs move.
    step("hold_before", 6'h08, 8'h4F, w(7, 1, 0, 0, 1, 0, 1));
    PHASE  = 6'h00;
    OPCODE = 8'h00;
    #2;
    check("hold_between_edges", MCODE, w(7, 1, 0, 0, 1, 0, 1));
    @(posedge CLK); #1;
    check("hold_after_edge", MCODE, w(1, 4'hF, 4'hE, 0, 3, 2, 0));

    // Reset in the middle of an interrupt push sequence.
    step("intr_pre_rst", 6'h22, 8'h00, psh_exp[2]);
    @(negedge CLK);
    RST   = 1'b1;
    PHASE = 6'h23;
    @(posedge CLK); #1;
    check("rst_mid_seq", MCODE, 25'h0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;
    check("resume_after_rst", MCODE, psh_exp[3]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
